// File: rtl/fifo_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_top_module                                               |
// | Function : single-clock byte FIFO, any DEPTH >= 2, drop on over/underflow|
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_top_module #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       o_fifo_full,
    output logic       o_fifo_empty
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic w_wr_acc;
    logic w_rd_acc;

    assign o_fifo_full  = (count_q == c_FULL_CNT);
    assign o_fifo_empty = (count_q == '0);
    assign rd_data      = rd_data_q;

    assign w_wr_acc = wr_en & ~o_fifo_full;
    assign w_rd_acc = rd_en & ~o_fifo_empty;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (w_wr_acc) begin
            wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (w_rd_acc) begin
            rd_ptr_d  = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_top_module                                            |
// | Function : directed + random bench for fifo_top_module, queue model      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_top_module;

    localparam int DEPTH = 12;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       o_fifo_full;
    logic       o_fifo_empty;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_rd = 8'h00;

    always #5 clk = ~clk;

    fifo_top_module #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .o_fifo_full  (o_fifo_full),
        .o_fifo_empty (o_fifo_empty)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":rd_data"}, rd_data, exp_rd);
        check({tag, ":full"}, {7'b0, o_fifo_full}, {7'b0, (model_q.size() == DEPTH)});
        check({tag, ":empty"}, {7'b0, o_fifo_empty}, {7'b0, (model_q.size() == 0)});
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd = 8'h00;
    endtask

    // One clock of stimulus; the model applies the accept rules to pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
        logic wacc;
        logic racc;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        wacc = w && (model_q.size() < DEPTH);
        racc = r && (model_q.size() != 0);
        if (racc) exp_rd = model_q.pop_front();
        if (wacc) model_q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held for 10 cycles
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill: 10x34, 10x28, 10xAB; only the first 12 bytes are stored
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, (i < 10) ? 8'h34 : (i < 20) ? 8'h28 : 8'hAB, "fill");
            if (i == 0)  check("fill_first_not_empty", {7'b0, o_fifo_empty}, 8'h00);
            if (i == 10) check("fill_not_full_at_11", {7'b0, o_fifo_full}, 8'h00);
            if (i == 11) check("fill_full_at_12", {7'b0, o_fifo_full}, 8'h01);
        end

        // Drain: 20 reads, constant expectations for the byte sequence
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain_value", rd_data, (i < 10) ? 8'h34 : 8'h28);
            if (i == 0)  check("drain_full_drop", {7'b0, o_fifo_full}, 8'h00);
            if (i == 11) check("drain_empty_at_12", {7'b0, o_fifo_empty}, 8'h01);
        end

        // Underflow: reads on empty leave rd_data alone
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, "underflow");
            check("underflow_hold", rd_data, 8'h28);
        end
        step(1'b1, 1'b0, 8'h77, "uf_write");
        step(1'b0, 1'b1, 8'h00, "uf_read");
        check("uf_read_value", rd_data, 8'h77);

        // Simultaneous on empty: write only, no fall-through
        step(1'b1, 1'b1, 8'h99, "sim_empty");
        check("sim_empty_hold", rd_data, 8'h77);
        step(1'b0, 1'b1, 8'h00, "sim_empty_read");
        check("sim_empty_value", rd_data, 8'h99);

        // Simultaneous at count=5 across pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "pre5");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h20 + i), "sim5");
            check("sim5_order", rd_data, (i < 5) ? 8'(8'h10 + i) : 8'(8'h20 + i - 5));
        end

        // Simultaneous at full: read wins, write dropped, count 12 -> 11
        while (model_q.size() < DEPTH) step(1'b1, 1'b0, 8'hC3, "to_full");
        check("at_full", {7'b0, o_fifo_full}, 8'h01);
        step(1'b1, 1'b1, 8'hEE, "sim_full");
        check("sim_full_deassert", {7'b0, o_fifo_full}, 8'h00);
        check("sim_full_count", 8'(model_q.size()), 8'd11);

        // Mid-operation asynchronous reset at count=7
        while (model_q.size() > 7) step(1'b0, 1'b1, 8'h00, "to7");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_empty", {7'b0, o_fifo_empty}, 8'h01);
        check("async_rst_full", {7'b0, o_fifo_full}, 8'h00);
        check("async_rst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h5A, "post_rst_wr");
        step(1'b1, 1'b0, 8'h5B, "post_rst_wr2");
        step(1'b0, 1'b1, 8'h00, "post_rst_rd");
        check("post_rst_first", rd_data, 8'h5A);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            int unsigned bias;
            bias = (i / 50) % 2;
            step(($urandom_range(0, 3) < (bias ? 3 : 1)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) < (bias ? 1 : 3)) ? 1'b1 : 1'b0,
                 8'($urandom), "random");
        end

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
